// File: rtl/pdes_pkg.sv
// pdes_pkg: run-state encoding, message field offsets and a sizing helper
// shared by the PHOLD scheduler and its round-robin arbiters.
package pdes_pkg;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] INIT     = 3'd1;
  localparam logic [2:0] RUNNING  = 3'd2;
  localparam logic [2:0] DRAIN    = 3'd3;
  localparam logic [2:0] FINISHED = 3'd4;

  // A message is {lp, time}: time sits in the low bits, lp directly above it.
  localparam int MSG_TIME_LSB = 0;

  function automatic int msgLpLsb(input int timeWid);
    return timeWid;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pdes_rr_arb.sv
// pdes_rr_arb: N-way round-robin arbiter; search starts at the pointer and
// the pointer moves past the winner only when the grant is used (adv).
module pdes_rr_arb
  import pdes_pkg::*;
#(
  parameter  int N  = 8,
  localparam int IW = (clog2(N) > 0) ? clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  gnt,
  output logic          any,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] r_ptr;
  int            w_cand;

  always_comb begin
    gnt    = '0;
    any    = 1'b0;
    idx    = '0;
    w_cand = 0;
    for (int i = 0; i < N; i++) begin
      w_cand = int'(r_ptr) + i;
      if (w_cand >= N) w_cand = w_cand - N;
      if (!any && req[w_cand]) begin
        any         = 1'b1;
        idx         = IW'(w_cand);
        gnt[w_cand] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (adv && any) begin
      r_ptr <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/pdes_sched.sv
// pdes_sched: PHOLD run controller - seeding, round-robin collect/dispatch,
// busy/GVT tracking, drain and causality check. Define PDES_SCHED_STATS_EN for stat counters.
module pdes_sched
  import pdes_pkg::*;
#(
  parameter int NUM_CORE     = 8,
  parameter int TIME_WID     = 16,
  parameter int LP_WID       = 3,
  parameter int NUM_INIT     = 4,
  parameter int SIM_END_TIME = 8000,
  parameter int MSG_WID      = LP_WID + TIME_WID
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         done,
  output logic [TIME_WID-1:0]          gvt,
  output logic                         causality_err,
  output logic                         q_enq,
  output logic [MSG_WID-1:0]           q_enq_data,
  output logic                         q_deq,
  input  logic [MSG_WID-1:0]           q_head,
  input  logic                         q_empty,
  input  logic                         q_full,
  input  logic [NUM_CORE-1:0]          core_ready,
  output logic [NUM_CORE-1:0]          disp_vld,
  output logic [MSG_WID-1:0]           disp_data,
  input  logic [NUM_CORE-1:0]          new_vld,
  input  logic [NUM_CORE*MSG_WID-1:0]  new_data,
  input  logic [NUM_CORE-1:0]          new_last,
  output logic [NUM_CORE-1:0]          new_ack,
  output logic [31:0]                  stat_disp,
  output logic [31:0]                  stat_new,
  output logic [31:0]                  stat_stall
);

  localparam int IW     = (clog2(NUM_CORE) > 0) ? clog2(NUM_CORE) : 1;
  localparam int LP_LSB = msgLpLsb(TIME_WID);
  localparam logic [TIME_WID-1:0] END_TIME = TIME_WID'(SIM_END_TIME);

  logic [2:0]          r_state;
  logic [31:0]         r_initCnt;
  logic [NUM_CORE-1:0] r_busy;
  logic [TIME_WID-1:0] r_coreTime [NUM_CORE];
  logic [TIME_WID-1:0] r_gvt;
  logic                r_causErr;

  logic                w_running, w_collPhase, w_startRun, w_gvtEnd;
  logic                w_collAny, w_dispAny, w_accept, w_disp;
  logic [NUM_CORE-1:0] w_collGnt, w_dispGnt, w_dispReq;
  logic [IW-1:0]       w_collIdx, w_dispIdx;
  logic [MSG_WID-1:0]  w_newMsg [NUM_CORE];
  logic [MSG_WID-1:0]  w_collMsg, w_seedMsg;
  logic [TIME_WID-1:0] w_collTime, w_headTime, w_cand;

  assign w_running   = (r_state == RUNNING);
  assign w_collPhase = w_running || (r_state == DRAIN);
  assign w_startRun  = (r_state == IDLE) && start;
  assign w_gvtEnd    = (r_gvt > END_TIME);
  assign w_dispReq   = core_ready & ~r_busy;

  pdes_rr_arb #(.N(NUM_CORE)) u_collArb (
    .clk (clk), .rst (rst), .req (new_vld), .adv (w_accept),
    .gnt (w_collGnt), .any (w_collAny), .idx (w_collIdx)
  );

  pdes_rr_arb #(.N(NUM_CORE)) u_dispArb (
    .clk (clk), .rst (rst), .req (w_dispReq), .adv (w_disp),
    .gnt (w_dispGnt), .any (w_dispAny), .idx (w_dispIdx)
  );

  always_comb begin
    for (int k = 0; k < NUM_CORE; k++) w_newMsg[k] = new_data[k*MSG_WID +: MSG_WID];
  end

  always_comb begin
    w_seedMsg = '0;
    w_seedMsg[LP_LSB +: LP_WID] = r_initCnt[LP_WID-1:0];
  end

  assign w_collMsg  = w_newMsg[w_collIdx];
  assign w_collTime = w_collMsg[MSG_TIME_LSB +: TIME_WID];
  assign w_headTime = q_head[MSG_TIME_LSB +: TIME_WID];

  // Collection wins the queue port; dispatch also stops the moment gvt passes the end time.
  assign w_accept = w_collPhase && w_collAny && !q_full;
  assign w_disp   = w_running && !w_gvtEnd && w_dispAny && !q_empty && !w_accept;

  assign q_enq         = (r_state == INIT) || w_accept;
  assign q_enq_data    = (r_state == INIT) ? w_seedMsg : (w_accept ? w_collMsg : '0);
  assign new_ack       = w_accept ? w_collGnt : '0;
  assign q_deq         = w_disp;
  assign disp_vld      = w_disp ? w_dispGnt : '0;
  assign disp_data     = w_disp ? q_head : '0;
  assign done          = (r_state == FINISHED);
  assign gvt           = r_gvt;
  assign causality_err = r_causErr;

  always_comb begin
    w_cand = '1;
    if (!q_empty) w_cand = w_headTime;
    for (int k = 0; k < NUM_CORE; k++) begin
      if (r_busy[k] && (r_coreTime[k] < w_cand)) w_cand = r_coreTime[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_initCnt <= '0;
    end else begin
      case (r_state)
        IDLE:     if (start) begin
                    r_state   <= INIT;
                    r_initCnt <= '0;
                  end
        INIT:     if (r_initCnt == 32'(NUM_INIT - 1)) r_state <= RUNNING;
                  else r_initCnt <= r_initCnt + 32'd1;
        RUNNING:  if (w_gvtEnd) r_state <= DRAIN;
        DRAIN:    if ((r_busy == '0) && (new_vld == '0)) r_state <= FINISHED;
        FINISHED: r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      for (int k = 0; k < NUM_CORE; k++) r_coreTime[k] <= '0;
    end else if (w_startRun) begin
      r_busy <= '0;
    end else begin
      if (w_accept && new_last[w_collIdx]) r_busy[w_collIdx] <= 1'b0;
      if (w_disp) begin
        r_busy[w_dispIdx]     <= 1'b1;
        r_coreTime[w_dispIdx] <= w_headTime;
      end
    end
  end

  // gvt only ratchets upward while a run is live; a fresh start zeroes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gvt     <= '0;
      r_causErr <= 1'b0;
    end else if (w_startRun) begin
      r_gvt     <= '0;
      r_causErr <= 1'b0;
    end else begin
      if (w_collPhase && (w_cand > r_gvt)) r_gvt <= w_cand;
      if (w_accept && (w_collTime < r_gvt)) r_causErr <= 1'b1;
    end
  end

`ifdef PDES_SCHED_STATS_EN
  logic [31:0] r_statDisp, r_statNew, r_statStall;
  logic        w_stall;

  assign w_stall = w_running && (((|new_vld) && q_full) || (q_empty && (|w_dispReq)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_statDisp  <= '0;
      r_statNew   <= '0;
      r_statStall <= '0;
    end else if (w_startRun) begin
      r_statDisp  <= '0;
      r_statNew   <= '0;
      r_statStall <= '0;
    end else begin
      if (w_disp && (r_statDisp != '1))    r_statDisp  <= r_statDisp + 32'd1;
      if (w_accept && (r_statNew != '1))   r_statNew   <= r_statNew + 32'd1;
      if (w_stall && (r_statStall != '1))  r_statStall <= r_statStall + 32'd1;
    end
  end

  assign stat_disp  = r_statDisp;
  assign stat_new   = r_statNew;
  assign stat_stall = r_statStall;
`else
  assign stat_disp  = '0;
  assign stat_new   = '0;
  assign stat_stall = '0;
`endif

endmodule
